nabp_mapper_scheduler: RTL
==========================

NABP_MAPPER_SCHEDULER -- requirements
Module: nabp_mapper_scheduler

Interface
REQ-001 SHALL have parameter ANGLE_W, default 8: width of angle index and angle count.
REQ-002 SHALL have parameter INIT_W, default 24: width of the mapper accumulator initial value.
REQ-003 SHALL have parameter BASE_W, default 24: width of the mapper accumulator increment.
REQ-004 SHALL have ports:
- clk  in  1  clock; all logic on rising edge
- reset_n  in  1  reset, synchronous, active-low
- start  in  1  begin a sweep over all angles
- num_angles  in  ANGLE_W  number of angles in the sweep, sampled on accepted start
- busy  out  1  sweep in progress
- sweep_done  out  1  one-cycle pulse at sweep end
- angle_idx  out  ANGLE_W  index of the angle currently mapped
- pt_rd  out  1  parameter table read strobe
- pt_addr  out  ANGLE_W  parameter table address
- pt_init  in  INIT_W  table accumulator initial value, valid 1 cycle after pt_rd
- pt_base  in  BASE_W  table accumulator increment, valid 1 cycle after pt_rd
- mp_accu_init  out  INIT_W  registered initial value to mapper
- mp_accu_base  out  BASE_W  registered increment to mapper
- sh_kick  out  1  one-cycle pulse starting shifter and mapper for one angle
- sh_done  in  1  shifter finished current angle
- err_unexp  out  1  sticky flag: sh_done seen outside RUN

Function
REQ-005 SHALL implement states IDLE, FETCH, LOAD, KICK, RUN, FINISH.
REQ-006 IDLE: start with num_angles!=0 -> FETCH, angle_idx=0, count latched; start with num_angles==0 -> FINISH (no kicks).
REQ-007 FETCH SHALL drive pt_rd=1 and pt_addr=angle_idx for exactly one cycle, then go to LOAD.
REQ-008 LOAD SHALL capture pt_init/pt_base into mp_accu_init/mp_accu_base, then go to KICK.
REQ-009 KICK SHALL drive sh_kick=1 for exactly one cycle, then go to RUN.
REQ-010 RUN on sh_done: if angle_idx==count-1 -> FINISH; else angle_idx+1, and -> FETCH.
REQ-011 FINISH SHALL pulse sweep_done for one cycle, then go to IDLE.
REQ-012 busy SHALL be 1 in every state except IDLE.
REQ-013 start while busy SHALL be ignored; latched count and angle_idx SHALL be unaffected.
REQ-014 sh_done in any state other than RUN SHALL be ignored for sequencing and SHALL set err_unexp.
REQ-015 err_unexp SHALL clear only on reset or on an accepted start.
REQ-016 mp_accu_init/mp_accu_base SHALL hold stable from LOAD until the next load, including across IDLE.
REQ-017 pt_rd SHALL be 0 and pt_addr SHALL hold its last value whenever not fetching.
REQ-018 Without prefetch, sh_kick SHALL occur 3 cycles after the sh_done that ended the previous angle.
REQ-019 First sh_kick SHALL occur 3 cycles after an accepted start.

Reset
REQ-020 reset_n=0 at a clock edge SHALL force IDLE and clear busy, sweep_done, sh_kick, pt_rd, err_unexp, angle_idx, pt_addr, mp_accu_init and mp_accu_base.
REQ-021 Reset mid-sweep SHALL abort without a sweep_done pulse; the next start SHALL begin at angle 0.

Configuration
REQ-022 Macro NABP_SCHED_PREFETCH_EN SHALL enable parameter prefetch; when undefined, REQ-007..REQ-010 and REQ-018 apply unchanged.
REQ-023 With prefetch: on the first RUN cycle, if angle_idx<count-1, pt_rd SHALL pulse with pt_addr=angle_idx+1.
REQ-024 With prefetch: the next cycle's table data SHALL be captured into shadow registers.
REQ-025 With prefetch: sh_done in RUN with angle_idx<count-1 SHALL load mp regs from shadow, increment angle_idx and go directly to KICK, giving sh_kick 1 cycle after sh_done.
REQ-026 With prefetch: sh_done arriving before the shadow capture completes SHALL fall back to FETCH.

Verification
REQ-027 Reset, then start with num_angles=0 -> sweep_done pulse 1 cycle later; no sh_kick; no pt_rd.
REQ-028 num_angles=3, table {(0x100,0x10),(0x200,0x20),(0x300,0x30)}, sh_done 10 cycles after each kick -> 3 kicks; mp values match the table in order; kick 3 cycles after each sh_done (1 with NABP_SCHED_PREFETCH_EN); one sweep_done.
REQ-029 start pulsed during RUN of angle 1 of 4 -> ignored; exactly 4 kicks; one sweep_done.
REQ-030 sh_done in IDLE -> err_unexp=1, no state change; next accepted start clears it.
REQ-031 reset_n low during RUN of angle 2 of 5 -> all outputs 0 next cycle; no sweep_done; restart fetches pt_addr=0.
REQ-032 Prefetch build, sh_done on the first RUN cycle -> fallback path used; kick 3 cycles after sh_done with correct angle parameters.

Source files
------------

// File: rtl/nabp_mapper_scheduler.sv
// -----------------------------------------------------------------------------
// nabp_mapper_scheduler
//
// Purpose:
//   Sequences a back-projection sweep over a set of angles. For every angle it
//   reads the mapper accumulator parameters (initial value and increment) from
//   an external parameter table, registers them towards the mapper, kicks the
//   shifter/mapper pair for one angle and waits for the shifter to report
//   completion. After the last angle a one-cycle sweep_done pulse is issued.
//
// Optional feature:
//   NABP_SCHED_PREFETCH_EN - when defined, the parameters of the next angle are
//   read while the current angle is still running and are held in shadow
//   registers. A completion then re-kicks one cycle later instead of three.
//   With the macro undefined every angle goes through FETCH/LOAD/KICK.
//
// Ports:
//   clk, reset_n          clock (rising edge) and synchronous active-low reset
//   start, num_angles     sweep request and number of angles (sampled on start)
//   busy, sweep_done      sweep in progress / one-cycle end-of-sweep pulse
//   angle_idx             index of the angle currently being mapped
//   pt_rd, pt_addr        parameter table read strobe and address
//   pt_init, pt_base      parameter table data, valid one cycle after pt_rd
//   mp_accu_init/base     registered accumulator parameters towards the mapper
//   sh_kick               one-cycle pulse starting shifter and mapper
//   sh_done               shifter finished the current angle
//   err_unexp             sticky flag: sh_done seen while not running an angle
// -----------------------------------------------------------------------------
module nabp_mapper_scheduler #(
  parameter int ANGLE_W = 8,
  parameter int INIT_W  = 24,
  parameter int BASE_W  = 24
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               start,
  input  logic [ANGLE_W-1:0] num_angles,
  output logic               busy,
  output logic               sweep_done,
  output logic [ANGLE_W-1:0] angle_idx,
  output logic               pt_rd,
  output logic [ANGLE_W-1:0] pt_addr,
  input  logic [INIT_W-1:0]  pt_init,
  input  logic [BASE_W-1:0]  pt_base,
  output logic [INIT_W-1:0]  mp_accu_init,
  output logic [BASE_W-1:0]  mp_accu_base,
  output logic               sh_kick,
  input  logic               sh_done,
  output logic               err_unexp
);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    KICK,
    RUN,
    FINISH
  } state_t;

  localparam logic [ANGLE_W-1:0] ANGLE_ONE = {{(ANGLE_W-1){1'b0}}, 1'b1};

  state_t             state_q;
  logic [ANGLE_W-1:0] count_q;
  logic [ANGLE_W-1:0] angle_idx_q;
  logic [ANGLE_W-1:0] angle_idx_d;
  logic [ANGLE_W-1:0] pt_addr_q;
  logic               pt_rd_q;
  logic               busy_q;
  logic               sweep_done_q;
  logic               sh_kick_q;
  logic               err_unexp_q;
  logic [INIT_W-1:0]  mp_init_q;
  logic [BASE_W-1:0]  mp_base_q;
  logic               last_angle;

`ifdef NABP_SCHED_PREFETCH_EN
  logic               pf_pend_q;
  logic               shadow_vld_q;
  logic [INIT_W-1:0]  shadow_init_q;
  logic [BASE_W-1:0]  shadow_base_q;
`endif

  // The latched count is never zero while an angle is active (a zero-angle
  // request goes straight to FINISH), so count_q - 1 cannot wrap here.
  assign last_angle  = (angle_idx_q == (count_q - ANGLE_ONE));
  assign angle_idx_d = angle_idx_q + ANGLE_ONE;

  // Sweep sequencer. Every output is a register that is set on the edge that
  // enters the state owning it, so each output lines up with its state.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      count_q      <= '0;
      angle_idx_q  <= '0;
      pt_addr_q    <= '0;
      pt_rd_q      <= 1'b0;
      busy_q       <= 1'b0;
      sweep_done_q <= 1'b0;
      sh_kick_q    <= 1'b0;
      err_unexp_q  <= 1'b0;
      mp_init_q    <= '0;
      mp_base_q    <= '0;
`ifdef NABP_SCHED_PREFETCH_EN
      pf_pend_q     <= 1'b0;
      shadow_vld_q  <= 1'b0;
      shadow_init_q <= '0;
      shadow_base_q <= '0;
`endif
    end else begin
      // Strobes default low so each one lasts exactly one cycle.
      pt_rd_q      <= 1'b0;
      sh_kick_q    <= 1'b0;
      sweep_done_q <= 1'b0;

      if (sh_done && (state_q != RUN)) begin
        err_unexp_q <= 1'b1;
      end

`ifdef NABP_SCHED_PREFETCH_EN
      // Table data answering last cycle's prefetch read is on the bus now.
      if (pf_pend_q) begin
        pf_pend_q     <= 1'b0;
        shadow_vld_q  <= 1'b1;
        shadow_init_q <= pt_init;
        shadow_base_q <= pt_base;
      end
`endif

      case (state_q)
        IDLE: begin
          if (start) begin
            // An accepted start clears the error flag unless a stray
            // completion arrives in the very same cycle.
            err_unexp_q <= sh_done;
            angle_idx_q <= '0;
            count_q     <= num_angles;
            busy_q      <= 1'b1;
            if (num_angles != '0) begin
              state_q   <= FETCH;
              pt_rd_q   <= 1'b1;
              pt_addr_q <= '0;
            end else begin
              state_q      <= FINISH;
              sweep_done_q <= 1'b1;
            end
          end
        end

        FETCH: begin
          state_q <= LOAD;
        end

        LOAD: begin
          mp_init_q <= pt_init;
          mp_base_q <= pt_base;
          sh_kick_q <= 1'b1;
          state_q   <= KICK;
        end

        KICK: begin
          state_q <= RUN;
`ifdef NABP_SCHED_PREFETCH_EN
          // Start reading the next angle's parameters on the first RUN cycle;
          // any shadow content from the previous angle is now stale.
          shadow_vld_q <= 1'b0;
          if (!last_angle) begin
            pt_rd_q   <= 1'b1;
            pt_addr_q <= angle_idx_d;
            pf_pend_q <= 1'b1;
          end
`endif
        end

        RUN: begin
          if (sh_done) begin
            if (last_angle) begin
              state_q      <= FINISH;
              sweep_done_q <= 1'b1;
            end else begin
              angle_idx_q <= angle_idx_d;
`ifdef NABP_SCHED_PREFETCH_EN
              if (shadow_vld_q) begin
                mp_init_q <= shadow_init_q;
                mp_base_q <= shadow_base_q;
                sh_kick_q <= 1'b1;
                state_q   <= KICK;
              end else begin
                // Completion beat the prefetch capture: take the slow path.
                state_q   <= FETCH;
                pt_rd_q   <= 1'b1;
                pt_addr_q <= angle_idx_d;
              end
`else
              state_q   <= FETCH;
              pt_rd_q   <= 1'b1;
              pt_addr_q <= angle_idx_d;
`endif
            end
          end
        end

        FINISH: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy         = busy_q;
  assign sweep_done   = sweep_done_q;
  assign angle_idx    = angle_idx_q;
  assign pt_rd        = pt_rd_q;
  assign pt_addr      = pt_addr_q;
  assign mp_accu_init = mp_init_q;
  assign mp_accu_base = mp_base_q;
  assign sh_kick      = sh_kick_q;
  assign err_unexp    = err_unexp_q;

endmodule
